// File: rtl/mem_sram_slave.sv
// rtl/mem_sram_slave.sv - single-port SRAM slave behind a valid/ready request/response port
// Optional build macro: MEM_SRAM_MISALIGN_CHECK_EN (flags addr[1:0]!=0 accesses as errors).
module mem_sram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 33-bit bounds so BASE_ADDR + 4*DEPTH_WORDS cannot wrap past 2^32
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'(DEPTH_WORDS) << 2);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // Storage array; deliberately has no reset
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          in_range;
  logic          misalign;
  logic          fault;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic [31:0]   rdata_d;
  logic          unused_offset_bits;

  assign offset   = req_addr - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign in_range = ({1'b0, req_addr} >= BASE_EXT) && ({1'b0, req_addr} < LIMIT_EXT);

`ifdef MEM_SRAM_MISALIGN_CHECK_EN
  assign misalign = (req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign fault  = !in_range || misalign;
  // req_ready_q is only ever high in IDLE, so req_* are ignored in every other state
  assign accept = req_valid && req_ready_q;

  // Writes and faulting accesses return zero read data
  assign rdata_d = (req_we || fault) ? 32'd0 : mem_q[idx];

  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

  // Commit the strobed bytes of an accepted, non-faulting write on the accepting edge
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) begin
          mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Transaction FSM: accept in IDLE, count wait cycles, hold the response until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            rdata_q     <= rdata_d;
            err_q       <= fault;
            if (WAIT_CYCLES == 0) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          cnt_q        <= 4'd0;
          req_ready_q  <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_sram_slave.sv
// tb/tb_mem_sram_slave.sv - self-checking bench for mem_sram_slave
module tb_mem_sram_slave;

  localparam int          W     = 1;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        req_we = 1'b0;
  logic [3:0]  req_wstrb = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mem_sram_slave #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wstrb (req_wstrb),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: word-indexed memory image plus address rules
  bit [31:0] mdl [int];

  function automatic bit mdl_err(input logic [31:0] a);
    bit e;
    e = (longint'(a) < longint'(BASE)) || (longint'(a) >= longint'(BASE) + 4 * DEPTH);
`ifdef MEM_SRAM_MISALIGN_CHECK_EN
    if (a[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic mdl_apply(input logic [31:0] a, input bit we, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd, output bit er);
    int        i;
    bit [31:0] w;
    er = mdl_err(a);
    rd = 32'd0;
    if (!er) begin
      i = int'((longint'(a) - longint'(BASE)) / 4);
      w = mdl.exists(i) ? mdl[i] : 32'd0;
      if (we) begin
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl[i] = w;
      end else begin
        rd = w;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One full transaction; while busy, a stray write request is held on req_* to prove it is ignored
  task automatic txn(input logic [31:0] a, input bit we, input logic [3:0] s, input logic [31:0] d,
                     input int hold, output logic [31:0] rd, output bit er, output int acc);
    int w;
    int lat;
    rd = 32'd0; er = 1'b0; acc = 0;
    @(negedge clk);
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    if (req_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL req_ready_timeout: req_ready=%b required 1", req_ready);
      return;
    end
    req_valid = 1'b1; req_addr = a; req_we = we; req_wstrb = s; req_wdata = d;
    @(posedge clk); #1;
    acc = cyc;
    req_addr = BASE + 32'd20; req_we = 1'b1; req_wstrb = 4'hF; req_wdata = $urandom;
    lat = 1;
    @(negedge clk);
    check("busy_req_ready", req_ready, 32'd0);
    while (resp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    check("resp_latency", lat, 1 + W);
    if (resp_valid !== 1'b1) begin req_valid = 1'b0; return; end
    rd = resp_rdata; er = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", resp_valid, 32'd1);
      check("hold_rdata", resp_rdata, rd);
      check("hold_err", resp_err, er);
      check("hold_req_ready", req_ready, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0; req_we = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, mrd, a, d;
    bit          er, mer, we;
    logic [3:0]  s;
    int          acc1, acc2, w;

    vecs.push_back('{32'h80000010, 1'b1, 4'hF, 32'hDEADBEEF, 32'h00000000, 1'b0});
    vecs.push_back('{32'h80000010, 1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{32'h80000010, 1'b1, 4'h1, 32'h000000AA, 32'h00000000, 1'b0});
    vecs.push_back('{32'h80000010, 1'b0, 4'h0, 32'h0,        32'hDEADBEAA, 1'b0});
    vecs.push_back('{32'h80000000, 1'b1, 4'hF, 32'h11223344, 32'h00000000, 1'b0});
    vecs.push_back('{32'h80000FFC, 1'b1, 4'hF, 32'hCAFEF00D, 32'h00000000, 1'b0});
    vecs.push_back('{32'h7FFFFFFC, 1'b0, 4'h0, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{32'h80001000, 1'b0, 4'h0, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{32'h7FFFFFFC, 1'b1, 4'hF, 32'h12345678, 32'h00000000, 1'b1});
    vecs.push_back('{32'h80001000, 1'b1, 4'hF, 32'h87654321, 32'h00000000, 1'b1});
    vecs.push_back('{32'h80000FFC, 1'b0, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0});
    vecs.push_back('{32'h80000000, 1'b0, 4'h0, 32'h0,        32'h11223344, 1'b0});
    vecs.push_back('{32'h80000010, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{32'h80000010, 1'b0, 4'h0, 32'h0,        32'hDEADBEAA, 1'b0});
    vecs.push_back('{32'h80000014, 1'b1, 4'hF, 32'hA1B2C3D4, 32'h00000000, 1'b0});
    vecs.push_back('{32'h80000014, 1'b1, 4'h6, 32'h00FFFF00, 32'h00000000, 1'b0});
    vecs.push_back('{32'h80000014, 1'b0, 4'h0, 32'h0,        32'hA1FFFFD4, 1'b0});
`ifdef MEM_SRAM_MISALIGN_CHECK_EN
    vecs.push_back('{32'h80000002, 1'b0, 4'h0, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{32'h80000013, 1'b1, 4'hF, 32'h0BADF00D, 32'h00000000, 1'b1});
`else
    vecs.push_back('{32'h80000002, 1'b0, 4'h0, 32'h0,        32'h11223344, 1'b0});
    vecs.push_back('{32'h80000013, 1'b1, 4'hF, 32'h0BADF00D, 32'h00000000, 1'b0});
`endif
    vecs.push_back('{32'h80000010, 1'b0, 4'h0, 32'h0,        32'h00000000, 1'b0});
    vecs.push_back('{32'h00000010, 1'b0, 4'h0, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{32'hFFFFFFFC, 1'b0, 4'h0, 32'h0,        32'h00000000, 1'b1});
`ifdef MEM_SRAM_MISALIGN_CHECK_EN
    vecs[vecs.size()-3].exp_rdata = 32'hDEADBEAA;
`else
    vecs[vecs.size()-3].exp_rdata = 32'h0BADF00D;
`endif

    // Reset values while held, and the single-edge wake-up after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 32'd0);
    check("rst_resp_valid", resp_valid, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", resp_err, 32'd0);
    rst = 1'b1;
    #1;
    check("rel_req_ready_before_edge", req_ready, 32'd0);
    @(posedge clk); @(negedge clk);
    check("rel_req_ready_after_edge", req_ready, 32'd1);
    check("rel_resp_valid", resp_valid, 32'd0);

    // Directed table
    foreach (vecs[k]) begin
      txn(vecs[k].addr, vecs[k].we, vecs[k].strb, vecs[k].wdata, 0, rd, er, acc1);
      check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
      check($sformatf("vec%0d_err", k), er, vecs[k].exp_err);
      mdl_apply(vecs[k].addr, vecs[k].we, vecs[k].strb, vecs[k].wdata, mrd, mer);
    end

    // Back-to-back throughput with immediate resp_ready
    txn(BASE + 32'd16, 1'b0, 4'h0, 32'h0, 0, rd, er, acc1);
    txn(BASE + 32'd20, 1'b0, 4'h0, 32'h0, 0, rd, er, acc2);
    check("b2b_spacing", acc2 - acc1, 2 + W);
    check("b2b_rdata", rd, 32'hA1FFFFD4);

    // Response back-pressure for 5 cycles, then the next request on the following cycle
    txn(BASE + 32'd16, 1'b0, 4'h0, 32'h0, 5, rd, er, acc1);
    check("bp_rdata", rd, mdl[4]);
    txn(BASE + 32'd20, 1'b0, 4'h0, 32'h0, 0, rd, er, acc2);
    check("bp_spacing", acc2 - acc1, 2 + W + 5);

    // Reset during WAIT after an accepted write: response discarded, write kept
    @(negedge clk);
    check("pre_wait_ready", req_ready, 32'd1);
    req_valid = 1'b1; req_addr = BASE + 32'd24; req_we = 1'b1; req_wstrb = 4'hF; req_wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    mdl_apply(BASE + 32'd24, 1'b1, 4'hF, 32'h5A5A5A5A, mrd, mer);
    #1 rst = 1'b0;
    #1;
    check("rstwait_resp_valid", resp_valid, 32'd0);
    check("rstwait_req_ready", req_ready, 32'd0);
    @(posedge clk); #1;
    check("rstwait_held_resp_valid", resp_valid, 32'd0);
    rst = 1'b1;
    #1;
    check("rstwait_rel_req_ready_0", req_ready, 32'd0);
    @(posedge clk); @(negedge clk);
    check("rstwait_rel_req_ready_1", req_ready, 32'd1);
    check("rstwait_rel_resp_valid", resp_valid, 32'd0);
    txn(BASE + 32'd24, 1'b0, 4'h0, 32'h0, 0, rd, er, acc1);
    check("rstwait_write_kept", rd, 32'h5A5A5A5A);
    check("rstwait_write_kept_err", er, 32'd0);

    // Reset during RESP: outputs clear asynchronously
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE + 32'd20; req_we = 1'b0; req_wstrb = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (resp_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    check("rstresp_reached", resp_valid, 32'd1);
    check("rstresp_rdata_before", resp_rdata, 32'hA1FFFFD4);
    #1 rst = 1'b0;
    #1;
    check("rstresp_resp_valid", resp_valid, 32'd0);
    check("rstresp_rdata", resp_rdata, 32'd0);
    check("rstresp_err", resp_err, 32'd0);
    check("rstresp_req_ready", req_ready, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rstresp_rel_req_ready", req_ready, 32'd1);

    // Randomized phase: fill the exercised words, then random traffic against the model
    for (int i = 0; i < 20; i++) begin
      a = BASE + 32'(4 * ((i < 16) ? i : (DEPTH - 20 + i)));
      d = $urandom;
      txn(a, 1'b1, 4'hF, d, 0, rd, er, acc1);
      mdl_apply(a, 1'b1, 4'hF, d, mrd, mer);
    end
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        6: a = BASE + 32'(4 * (DEPTH - 4 + $urandom_range(0, 3))) + 32'($urandom_range(0, 3));
        7: a = BASE - 32'd1 - 32'($urandom_range(0, 7));
        8: a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
        default: a = $urandom & 32'h7FFFFFFF;
      endcase
      we = 1'($urandom_range(0, 1));
      s  = 4'($urandom_range(0, 15));
      d  = $urandom;
      txn(a, we, s, d, $urandom_range(0, 2), rd, er, acc1);
      mdl_apply(a, we, s, d, mrd, mer);
      check($sformatf("rnd%0d_rdata@%h", n, a), rd, mrd);
      check($sformatf("rnd%0d_err@%h", n, a), er, mer);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
